// File: rtl/param_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_result_fifo
// Brief    : Single-clock read-result FIFO, registered dout/valid, occupancy
//            output. Define FIFO_ERR_FLAGS_EN for sticky overflow/underflow.
// Revision : 1.0 - initial release
// ============================================================================
module param_result_fifo #(
  parameter int WIDTH            = 89,
  parameter int DEPTH            = 8,
  parameter int PROG_FULL_THRESH = 3,
  parameter int CNT_W            = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic             prog_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             empty,
  output logic [CNT_W-1:0] count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int             PTR_W       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_THRESH    = CNT_W'(PROG_FULL_THRESH);
  localparam logic [PTR_W-1:0] c_LAST_PTR  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_empty;
  logic             w_full;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_DEPTH_CNT);
  assign w_rd_acc = rd_en & ~w_empty;
  // A write into a full FIFO is allowed when a read frees a slot this cycle.
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (wr_en & ~w_wr_acc);
      r_underflow <= r_underflow | (rd_en & w_empty);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign full      = w_full;
  assign prog_full = (r_count >= c_THRESH);
  assign empty     = w_empty;
  assign count     = r_count;
  assign dout      = r_dout;
  assign valid     = r_valid;

endmodule
`default_nettype wire
